// File: rtl/brightness_pkg.sv
// ---------------------------------------------------------------------------
// brightness_pkg
// Shared definitions for the brightness control stage and the image_brightness
// pixel path: level width, the unity level, the per-key FSM state encoding and
// a helper used to size the shared timing counters.
// ---------------------------------------------------------------------------
package brightness_pkg;

   // Width of a brightness level and the level that leaves pixels untouched
   localparam int LVL_W     = 8;
   localparam int LVL_UNITY = 100;

   // Per-key state: IDLE waits for a press, WAIT covers the hold before
   // auto-repeat begins, RPT is the repeat phase, and LOCK is entered when both
   // keys are held together and left only once both are released
   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RPT,
      LOCK
   } key_state_t;

   // Result of one evaluation of a key FSM
   typedef struct packed {
      key_state_t nxt;
      logic       step;
      logic       clr;
   } key_fsm_t;

   // Largest of three cycle counts, never below 2 so a counter sized with
   // $clog2 of the result is at least one bit wide
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 2) ? 2 : m;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Brings one raw, asynchronous, active-low key into the clk domain and filters
// out bounce. The filtered level only follows the synchronised level after it
// has differed from the filtered value for DEBOUNCE_CYC consecutive cycles.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset (filtered level -> released)
//   key_n       raw key, active low, asynchronous to clk
//   key_filt_n  debounced key level, active low
// ---------------------------------------------------------------------------
module key_debounce
   import brightness_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int CNT_W        = $clog2(DEBOUNCE_CYC)
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_filt_n
);

   logic             sync0;
   logic             sync1;
   logic [CNT_W-1:0] stable_cnt;

   // Two-flop synchroniser followed by the stability counter. Counting only
   // while the synchronised level disagrees with the filtered level means any
   // return to the old level (a bounce) clears the count, so only a level that
   // holds for the full window is accepted. Everything restarts as released
   // on reset, so a key held through reset is debounced afresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0      <= 1'b1;
         sync1      <= 1'b1;
         key_filt_n <= 1'b1;
         stable_cnt <= '0;
      end else begin
         sync0 <= key_n;
         sync1 <= sync0;
         if (sync1 == key_filt_n) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            key_filt_n <= sync1;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/brightness_key_ctrl.sv
// ---------------------------------------------------------------------------
// brightness_key_ctrl
// Turns the up/down push keys into the brightness level used by
// image_brightness. Each key is debounced, drives its own press/auto-repeat
// FSM, and steps a saturating target level. Pressing both keys restores the
// default level once. The target is copied to the pixel path only on a rising
// edge of i_vs so a frame never changes brightness part-way through.
//
// Ports
//   clk             system clock, single domain
//   rst             synchronous active-high reset
//   key_up_n        raw up key, active low, asynchronous
//   key_dn_n        raw down key, active low, asynchronous
//   i_vs            vertical sync of the video stream, active high
//   brightness_cnt  committed level, changes one clk after an i_vs rise
//   o_target        pending level, updated on every step/restore event
//   o_step          one-clk pulse per accepted step or restore event
// ---------------------------------------------------------------------------
module brightness_key_ctrl
   import brightness_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int REPEAT_DLY   = 25_000_000,
   parameter int REPEAT_PER   = 5_000_000,
   parameter int STEP         = 5,
   parameter int LVL_MIN      = 0,
   parameter int LVL_MAX      = 200,
   parameter int LVL_DEF      = LVL_UNITY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_up_n,
   input  logic             key_dn_n,
   input  logic             i_vs,
   output logic [LVL_W-1:0] brightness_cnt,
   output logic [LVL_W-1:0] o_target,
   output logic             o_step
);

   // One width serves the debounce and hold counters; each only counts to N-1
   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER));

   logic             up_filt_n;
   logic             dn_filt_n;
   logic             up_pressed;
   logic             dn_pressed;
   logic             both_released;
   logic             restore;
   key_state_t       st_up;
   key_state_t       st_dn;
   key_fsm_t         fsm_up;
   key_fsm_t         fsm_dn;
   logic [CNT_W-1:0] hold_up;
   logic [CNT_W-1:0] hold_dn;
   logic [LVL_W:0]   sum_up;
   logic [LVL_W-1:0] lvl_up;
   logic [LVL_W-1:0] lvl_dn;
   logic             vs_d;

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_deb_up (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_up_n),
      .key_filt_n (up_filt_n)
   );

   key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_deb_dn (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_dn_n),
      .key_filt_n (dn_filt_n)
   );

   assign up_pressed    = ~up_filt_n;
   assign dn_pressed    = ~dn_filt_n;
   assign both_released = up_filt_n & dn_filt_n;

   // Next-state rule shared by both keys. A step is emitted on the initial
   // press, once after the repeat delay, then once per repeat period. The hold
   // counter is cleared whenever a step fires or the key is let go.
   function automatic key_fsm_t key_fsm(input key_state_t st,
                                        input logic pressed,
                                        input logic [CNT_W-1:0] hold,
                                        input logic both_rel);
      key_fsm_t r;
      r.nxt  = st;
      r.step = 1'b0;
      r.clr  = 1'b0;
      case (st)
         IDLE: begin
            if (pressed) begin
               r.nxt  = WAIT;
               r.step = 1'b1;
               r.clr  = 1'b1;
            end
         end
         WAIT: begin
            if (!pressed) begin
               r.nxt = IDLE;
               r.clr = 1'b1;
            end else if (hold == CNT_W'(REPEAT_DLY - 1)) begin
               r.nxt  = RPT;
               r.step = 1'b1;
               r.clr  = 1'b1;
            end
         end
         RPT: begin
            if (!pressed) begin
               r.nxt = IDLE;
               r.clr = 1'b1;
            end else if (hold == CNT_W'(REPEAT_PER - 1)) begin
               r.step = 1'b1;
               r.clr  = 1'b1;
            end
         end
         LOCK: begin
            r.clr = 1'b1;
            if (both_rel) begin
               r.nxt = IDLE;
            end
         end
         default: begin
            r.nxt = IDLE;
            r.clr = 1'b1;
         end
      endcase
      return r;
   endfunction

   // Evaluate both key FSMs, then let the two-key restore take priority: it
   // fires once when both keys are seen pressed outside LOCK, cancels any
   // per-key step in that cycle and parks both FSMs in LOCK. The two FSMs
   // always enter and leave LOCK together, so checking one of them suffices.
   always_comb begin
      fsm_up  = key_fsm(st_up, up_pressed, hold_up, both_released);
      fsm_dn  = key_fsm(st_dn, dn_pressed, hold_dn, both_released);
      restore = up_pressed & dn_pressed & (st_up != LOCK);
      if (restore) begin
         fsm_up.nxt  = LOCK;
         fsm_up.step = 1'b0;
         fsm_up.clr  = 1'b1;
         fsm_dn.nxt  = LOCK;
         fsm_dn.step = 1'b0;
         fsm_dn.clr  = 1'b1;
      end
   end

   // State registers and hold counters. Counters only advance in the states
   // that time a hold, so they sit at zero in IDLE and LOCK.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_up   <= IDLE;
         st_dn   <= IDLE;
         hold_up <= '0;
         hold_dn <= '0;
      end else begin
         st_up <= fsm_up.nxt;
         st_dn <= fsm_dn.nxt;
         if (fsm_up.clr) begin
            hold_up <= '0;
         end else if (st_up == WAIT || st_up == RPT) begin
            hold_up <= hold_up + CNT_W'(1);
         end
         if (fsm_dn.clr) begin
            hold_dn <= '0;
         end else if (st_dn == WAIT || st_dn == RPT) begin
            hold_dn <= hold_dn + CNT_W'(1);
         end
      end
   end

   // Saturating step values, computed one bit wider so the up sum cannot wrap
   // and the down path clamps before it could underflow
   always_comb begin
      sum_up = {1'b0, o_target} + (LVL_W + 1)'(STEP);
      lvl_up = (sum_up > (LVL_W + 1)'(LVL_MAX)) ? LVL_W'(LVL_MAX) : sum_up[LVL_W-1:0];
      lvl_dn = ({1'b0, o_target} < (LVL_W + 1)'(LVL_MIN + STEP)) ?
               LVL_W'(LVL_MIN) : o_target - LVL_W'(STEP);
   end

   // Pending target and step pulse. A step at a limit still pulses o_step
   // while the target stays clamped. The two per-key steps can never coincide
   // because two pressed keys always turn into a restore instead.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_target <= LVL_W'(LVL_DEF);
         o_step   <= 1'b0;
      end else begin
         o_step <= restore | fsm_up.step | fsm_dn.step;
         if (restore) begin
            o_target <= LVL_W'(LVL_DEF);
         end else if (fsm_up.step) begin
            o_target <= lvl_up;
         end else if (fsm_dn.step) begin
            o_target <= lvl_dn;
         end
      end
   end

   // Frame commit. On an i_vs rise the register copies the target as it stood
   // before this edge, so a step landing on the same cycle waits for the next
   // frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d           <= 1'b0;
         brightness_cnt <= LVL_W'(LVL_DEF);
      end else begin
         vs_d <= i_vs;
         if (i_vs && !vs_d) begin
            brightness_cnt <= o_target;
         end
      end
   end

endmodule
